// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: the canonical NOP, the default reset PC
// and the fetch controller state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2,
        HELD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble wins over load; with neither load nor hold
// asserted the register drops to a bubble so stale instructions never repeat.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic        hold,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    // A bubble only replaces the instruction; PCD/PCPlus4D keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
            PCD      <= RESET_PC;
            PCPlus4D <= RESET_PC + 32'd4;
        end else if (bubble) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (load) begin
            InstrD   <= instr;
            ValidD   <= 1'b1;
            PCD      <= pc;
            PCPlus4D <= pc + 32'd4;
        end else if (!hold) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one request at a time to instruction memory,
// buffers a word when decode is stalled and drops responses made stale by redirects.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReqF,
    output logic [31:0] ImemAddrF,
    input  logic        ImemGntF,
    input  logic        ImemAckF,
    input  logic [31:0] ImemRDataF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_t state, stateNext;
    logic [31:0]  pcF, pcNext;
    logic [31:0]  holdInstr, holdNext;
    logic [31:0]  deliverInstr;
    logic         deliver;
    logic         rstOutstanding;
    logic [1:0]   unusedTargetBits;

    assign unusedTargetBits = PCTargetE[1:0];
    assign ImemReqF  = (state == REQ);
    assign ImemAddrF = pcF;

    // A response still owed by memory must be swallowed even across a reset.
    assign rstOutstanding = ((state == WAIT || state == KILL) && !ImemAckF) ||
                            (state == REQ && ImemGntF);

    always_comb begin
        stateNext    = state;
        pcNext       = pcF;
        holdNext     = holdInstr;
        deliver      = 1'b0;
        deliverInstr = ImemRDataF;
        case (state)
            REQ: begin
                if (ImemGntF) stateNext = PCSrcE ? KILL : WAIT;
            end
            WAIT: begin
                if (PCSrcE) begin
                    stateNext = ImemAckF ? REQ : KILL;
                end else if (ImemAckF) begin
                    if (StallD || FlushD) begin
                        holdNext  = ImemRDataF;
                        stateNext = HELD;
                    end else begin
                        deliver   = 1'b1;
                        stateNext = REQ;
                    end
                end
            end
            KILL: begin
                if (ImemAckF) stateNext = REQ;
            end
            HELD: begin
                if (PCSrcE) begin
                    stateNext = REQ;
                end else if (!StallD && !FlushD) begin
                    deliver      = 1'b1;
                    deliverInstr = holdInstr;
                    stateNext    = REQ;
                end
            end
            default: stateNext = REQ;
        endcase
        if (PCSrcE) begin
            pcNext = {PCTargetE[31:2], 2'b00};
        end else if (deliver) begin
            pcNext = pcF + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= rstOutstanding ? KILL : REQ;
            pcF       <= RESET_PC;
            holdInstr <= NOP_INSTR;
        end else begin
            state     <= stateNext;
            pcF       <= pcNext;
            holdInstr <= holdNext;
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (deliver),
        .bubble   (PCSrcE || FlushD),
        .hold     (StallD),
        .instr    (deliverInstr),
        .pc       (pcF),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a single-outstanding memory responder,
// a protocol-level scoreboard of expected deliveries, and directed scenario tasks.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReqF, ImemGntF, ImemAckF;
    logic [31:0] ImemAddrF, ImemRDataF;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcPlus4;
    } expect_t;

    expect_t expQ[$];
    int      errors = 0;
    int      checks = 0;
    int      popCount = 0;
    bit      rspEnable = 0;
    int      ackLat = 1;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .ImemReqF   (ImemReqF),
        .ImemAddrF  (ImemAddrF),
        .ImemGntF   (ImemGntF),
        .ImemAckF   (ImemAckF),
        .ImemRDataF (ImemRDataF),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        if (a == 32'h0000_0004) return 32'h0010_0113;
        return {a[21:2], 12'h013};
    endfunction

    // Memory responder: grants immediately, acks ackLat cycles after the grant.
    initial begin : responder
        bit          busy;
        int          ackCnt;
        logic [31:0] rspAddr;
        busy = 0; ackCnt = 0; rspAddr = '0;
        ImemGntF = 1'b0; ImemAckF = 1'b0; ImemRDataF = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (ImemGntF) begin
                busy   = 1;
                ackCnt = ackLat - 1;
            end
            ImemGntF   = 1'b0;
            ImemAckF   = 1'b0;
            ImemRDataF = 32'hDEAD_BEEF;
            if (busy) begin
                if (ackCnt == 0) begin
                    ImemAckF   = 1'b1;
                    ImemRDataF = memWord(rspAddr);
                    busy       = 0;
                end else begin
                    ackCnt--;
                end
            end else if (rspEnable && ImemReqF) begin
                ImemGntF = 1'b1;
                rspAddr  = ImemAddrF;
            end
        end
    end

    // Expectation model: which acked words must reach decode, and when.
    bit          outstanding = 0;
    bit          killFlag = 0;
    bit          heldValid = 0;
    logic [31:0] outAddr;
    expect_t     heldEntry;

    initial begin : model
        expect_t e;
        forever begin
            @(posedge clk);
            if (heldValid) begin
                if (rst || PCSrcE) begin
                    heldValid = 0;
                end else if (!StallD && !FlushD) begin
                    expQ.push_back(heldEntry);
                    heldValid = 0;
                end
            end
            if (ImemGntF && ImemReqF) begin
                outstanding = 1;
                killFlag    = rst || PCSrcE;
                outAddr     = ImemAddrF;
            end else if (outstanding && (rst || PCSrcE)) begin
                killFlag = 1;
            end
            if (ImemAckF && outstanding) begin
                if (!killFlag) begin
                    e = '{outAddr, memWord(outAddr), outAddr + 32'd4};
                    if (StallD || FlushD) begin
                        heldEntry = e;
                        heldValid = 1;
                    end else begin
                        expQ.push_back(e);
                    end
                end
                outstanding = 0;
            end
        end
    end

    // Monitor: every fresh IF/ID load is popped against the model.
    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (ValidD && !StallD) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got pc=%h instr=%h, required no delivery", PCD, InstrD);
                end else begin
                    e = expQ.pop_front();
                    popCount++;
                    if (PCD !== e.pc || InstrD !== e.instr || PCPlus4D !== e.pcPlus4) begin
                        errors++;
                        $display("[TB] FAIL sb_deliver: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                                 PCD, InstrD, PCPlus4D, e.pc, e.instr, e.pcPlus4);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitDelivery(output bit ok, output int cycles);
        ok = 0;
        cycles = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (ValidD && !StallD) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic waitGrant(output bit ok);
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            if (ImemGntF && ImemReqF) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ValidD !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b required 0", ValidD); end
        checks++;
        if (InstrD !== NOP_INSTR) begin errors++; $display("[TB] FAIL reset_instr: got %h required %h", InstrD, NOP_INSTR); end
        checks++;
        if (PCD !== RESET_PC) begin errors++; $display("[TB] FAIL reset_pcd: got %h required %h", PCD, RESET_PC); end
        checks++;
        if (PCPlus4D !== RESET_PC + 32'd4) begin errors++; $display("[TB] FAIL reset_pcplus4: got %h required %h", PCPlus4D, RESET_PC + 32'd4); end
        checks++;
        if (ImemAddrF !== RESET_PC) begin errors++; $display("[TB] FAIL reset_addr: got %h required %h", ImemAddrF, RESET_PC); end
        checks++;
        if (ImemReqF !== 1'b1) begin errors++; $display("[TB] FAIL reset_req: got %0b required 1", ImemReqF); end
    endtask

    task automatic test_sequential();
        bit ok;
        int cyc;
        @(negedge clk);
        rst = 1'b0;
        rspEnable = 1;
        waitDelivery(ok, cyc);
        checks++;
        if (!ok || InstrD !== 32'h0050_0093 || PCD !== 32'h0 || PCPlus4D !== 32'h4) begin
            errors++;
            $display("[TB] FAIL seq_first: got ok=%0b instr=%h pc=%h pc4=%h required instr=00500093 pc=0 pc4=4", ok, InstrD, PCD, PCPlus4D);
        end
        waitDelivery(ok, cyc);
        checks++;
        if (!ok || InstrD !== 32'h0010_0113 || PCD !== 32'h4 || PCPlus4D !== 32'h8) begin
            errors++;
            $display("[TB] FAIL seq_second: got ok=%0b instr=%h pc=%h pc4=%h required instr=00100113 pc=4 pc4=8", ok, InstrD, PCD, PCPlus4D);
        end
        checks++;
        if (cyc != 2) begin errors++; $display("[TB] FAIL seq_throughput: got %0d cycles required 2", cyc); end
    endtask

    task automatic test_stall();
        bit          ok;
        int          cyc;
        logic [31:0] i0, p0;
        waitDelivery(ok, cyc);
        i0 = InstrD;
        p0 = PCD;
        @(negedge clk);
        StallD = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (!ok || InstrD !== i0 || PCD !== p0 || ValidD !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold: got instr=%h pc=%h valid=%0b required instr=%h pc=%h valid=1", InstrD, PCD, ValidD, i0, p0);
            end
            checks++;
            if (ImemReqF !== 1'b0) begin errors++; $display("[TB] FAIL stall_noreq: got %0b required 0", ImemReqF); end
        end
        @(negedge clk);
        StallD = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ValidD !== 1'b1 || PCD !== p0 + 32'd4 || InstrD !== memWord(p0 + 32'd4)) begin
            errors++;
            $display("[TB] FAIL stall_release: got valid=%0b pc=%h instr=%h required valid=1 pc=%h instr=%h", ValidD, PCD, InstrD, p0 + 32'd4, memWord(p0 + 32'd4));
        end
        @(posedge clk);
        #1;
        checks++;
        if (ValidD !== 1'b0) begin errors++; $display("[TB] FAIL stall_once: got valid=%0b required 0", ValidD); end
    endtask

    task automatic test_redirect();
        bit ok;
        int cyc;
        @(negedge clk);
        ackLat = 3;
        waitGrant(ok);
        @(negedge clk);
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0100;
        @(posedge clk);
        #1;
        checks++;
        if (!ok || ValidD !== 1'b0) begin errors++; $display("[TB] FAIL redirect_bubble: got ok=%0b valid=%0b required valid=0", ok, ValidD); end
        checks++;
        if (ImemAddrF !== 32'h0000_0100) begin errors++; $display("[TB] FAIL redirect_addr: got %h required 00000100", ImemAddrF); end
        checks++;
        if (ImemReqF !== 1'b0) begin errors++; $display("[TB] FAIL redirect_kill: got req=%0b required 0", ImemReqF); end
        @(negedge clk);
        PCSrcE = 1'b0;
        waitDelivery(ok, cyc);
        checks++;
        if (!ok || PCD !== 32'h100 || InstrD !== memWord(32'h100) || PCPlus4D !== 32'h104) begin
            errors++;
            $display("[TB] FAIL redirect_target: got ok=%0b pc=%h instr=%h pc4=%h required pc=100 instr=%h pc4=104", ok, PCD, InstrD, PCPlus4D, memWord(32'h100));
        end
        @(negedge clk);
        ackLat = 1;
    endtask

    task automatic test_misaligned();
        bit ok;
        int cyc;
        @(negedge clk);
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0103;
        @(posedge clk);
        #1;
        checks++;
        if (ImemAddrF !== 32'h0000_0100) begin errors++; $display("[TB] FAIL misaligned_addr: got %h required 00000100", ImemAddrF); end
        @(negedge clk);
        PCSrcE = 1'b0;
        waitDelivery(ok, cyc);
        checks++;
        if (!ok || PCD !== 32'h100) begin errors++; $display("[TB] FAIL misaligned_pcd: got ok=%0b pc=%h required 00000100", ok, PCD); end
        @(negedge clk);
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        @(negedge clk);
        PCSrcE = 1'b0;
        waitDelivery(ok, cyc);
        checks++;
        if (!ok || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_pcplus4: got ok=%0b pc=%h pc4=%h required pc=fffffffc pc4=0", ok, PCD, PCPlus4D);
        end
    endtask

    task automatic test_flush();
        bit          ok;
        int          cyc;
        logic [31:0] p0;
        waitDelivery(ok, cyc);
        @(negedge clk);
        FlushD = 1'b1;
        StallD = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (!ok || ValidD !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got ok=%0b valid=%0b required 0", ok, ValidD); end
        repeat (2) @(negedge clk);
        FlushD = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ValidD !== 1'b0) begin errors++; $display("[TB] FAIL stall_bubble_hold: got valid=%0b required 0", ValidD); end
        @(negedge clk);
        StallD = 1'b0;
        waitDelivery(ok, cyc);
        p0 = PCD;
        @(negedge clk);
        @(negedge clk);
        FlushD = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (!ok || ValidD !== 1'b0) begin errors++; $display("[TB] FAIL flush_bubble: got ok=%0b valid=%0b required 0", ok, ValidD); end
        @(negedge clk);
        FlushD = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ValidD !== 1'b1 || PCD !== p0 + 32'd4) begin
            errors++;
            $display("[TB] FAIL flush_not_lost: got valid=%0b pc=%h required valid=1 pc=%h", ValidD, PCD, p0 + 32'd4);
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        int cyc;
        @(negedge clk);
        ackLat = 3;
        waitGrant(ok);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (!ok || ValidD !== 1'b0 || PCD !== RESET_PC || ImemAddrF !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL midrst_state: got ok=%0b valid=%0b pc=%h addr=%h required valid=0 pc=%h addr=%h", ok, ValidD, PCD, ImemAddrF, RESET_PC, RESET_PC);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ImemReqF !== 1'b0) begin errors++; $display("[TB] FAIL midrst_kill: got req=%0b required 0", ImemReqF); end
        @(negedge clk);
        ackLat = 1;
        waitDelivery(ok, cyc);
        checks++;
        if (!ok || PCD !== RESET_PC || InstrD !== memWord(RESET_PC)) begin
            errors++;
            $display("[TB] FAIL midrst_first: got ok=%0b pc=%h instr=%h required pc=%h instr=%h", ok, PCD, InstrD, RESET_PC, memWord(RESET_PC));
        end
    endtask

    task automatic test_drain();
        @(negedge clk);
        rspEnable = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!outstanding && !heldValid && expQ.size() == 0) break;
        end
        checks++;
        if (expQ.size() != 0 || heldValid) begin
            errors++;
            $display("[TB] FAIL drain_empty: got %0d pending required 0", expQ.size() + int'(heldValid));
        end
        checks++;
        if (popCount < 12) begin errors++; $display("[TB] FAIL drain_count: got %0d deliveries required at least 12", popCount); end
    endtask

    initial begin : main
        rst = 1'b1;
        StallD = 1'b0;
        FlushD = 1'b0;
        PCSrcE = 1'b0;
        PCTargetE = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned();
        test_flush();
        test_reset_midflight();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
